// File: rtl/debug_rom_fetcher.sv
// Debug ROM fetcher: reads a run of 64-bit words from the debug ROM and
// streams them out as 32-bit instructions, low half first, with buffering
// and backpressure.
module debug_rom_fetcher #(
  parameter int FifoDepth = 4,
  parameter int CntW      = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [63:0]     base_addr_i,
  input  logic [CntW-1:0] num_words_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rom_req_o,
  output logic [63:0]     rom_addr_o,
  input  logic [63:0]     rom_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o
);

  localparam int PtrW   = $clog2(FifoDepth);
  localparam int CountW = $clog2(FifoDepth + 1);
  localparam logic [CountW:0] DepthL = (CountW + 1)'(FifoDepth);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [63:0]       addr_q, addr_d;
  logic [CntW-1:0]   remain_q, remain_d;
  logic              inflight_q;
  logic              zeroDone_q, zeroDone_d;
  logic              req, drainDone, hasCredit;

  logic [63:0]       fifoMem_q [FifoDepth];
  logic [PtrW-1:0]   rdPtr_q, wrPtr_q;
  logic [CountW-1:0] count_q;
  logic              half_q;
  logic              push, pop, transfer, fifoEmpty;
  logic [63:0]       headWord;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A request is only issued if the word it returns is guaranteed a slot;
  // a pop happening this cycle is deliberately not counted as free space.
  assign hasCredit = ({1'b0, count_q} + (CountW + 1)'(inflight_q)) < DepthL;
  assign fifoEmpty = (count_q == '0);

  // Next-state logic: sequencing of start, issue and drain, with abort overriding all.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    zeroDone_d = 1'b0;
    req        = 1'b0;
    drainDone  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (num_words_i != '0) begin
            addr_d   = base_addr_i & ~64'h7;
            remain_d = num_words_i;
            state_d  = StFetch;
          end else begin
            zeroDone_d = 1'b1;
          end
        end
      end
      StFetch: begin
        if (hasCredit) begin
          req      = 1'b1;
          addr_d   = addr_q + 64'd8;
          remain_d = remain_q - CntW'(1);
          if (remain_q == CntW'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifoEmpty && !inflight_q) begin
          drainDone = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort_i) begin
      state_d    = StIdle;
      req        = 1'b0;
      drainDone  = 1'b0;
      zeroDone_d = 1'b0;
    end
  end

  // Control registers: state, running address, words left, in-flight flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      zeroDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= req;
      zeroDone_q <= zeroDone_d;
    end
  end

  // The returning word is dropped if an abort or reset lands on its arrival cycle.
  assign push     = inflight_q && !abort_i && !rst_i;
  assign transfer = instr_valid_o && instr_ready_i && !abort_i;
  assign pop      = transfer && half_q;

  // FIFO bookkeeping and half-select; abort flushes everything.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      half_q  <= 1'b0;
    end else begin
      if (push) wrPtr_q <= nextPtr(wrPtr_q);
      if (pop)  rdPtr_q <= nextPtr(rdPtr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
      if (transfer) half_q <= ~half_q;
    end
  end

  // FIFO storage; contents are don't-care until counted valid.
  always_ff @(posedge clk_i) begin
    if (push) fifoMem_q[wrPtr_q] <= rom_rdata_i;
  end

  assign headWord      = fifoMem_q[rdPtr_q];
  assign busy_o        = (state_q != StIdle);
  assign done_o        = zeroDone_q | drainDone;
  assign rom_req_o     = req;
  assign rom_addr_o    = req ? addr_q : '0;
  assign instr_valid_o = !fifoEmpty;
  assign instr_o       = instr_valid_o ? (half_q ? headWord[63:32] : headWord[31:0]) : '0;

endmodule
